// File: rtl/fetch_unit_if.sv
// Memory/decoder side bus of the fetch unit: address and instruction out,
// data byte and decoder verdicts in.
interface fetch_unit_if;
   logic [7:0] dataBus;
   logic       doJump;
   logic       immediate;
   logic [7:0] ir;
   logic [7:0] pc;

   modport master (
      input  dataBus,
      input  doJump,
      input  immediate,
      output ir,
      output pc
   );

   modport slave (
      output dataBus,
      output doJump,
      output immediate,
      input  ir,
      input  pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Two-phase instruction fetch/execute sequencer with halt and single-step control.
//
// state | meaning
// HALT  | idle; pc/ir/instrCount hold; leaves on run or a step rising edge
// FETCH | latch instruction byte from dataBus into ir, advance pc
// EXEC  | apply jump/immediate to pc, retire instruction
// BAD   | unreachable encoding; recovers to HALT on the next clock
module fetch_unit (
   input  logic               clk,
   input  logic               resetBar,
   input  logic               run,
   input  logic               step,
   fetch_unit_if.master       bus,
   output logic [1:0]         phase,
   output logic               fetchStrobe,
   output logic               execValid,
   output logic               halted,
   output logic [15:0]        instrCount
);

   typedef enum logic [1:0] {
      HALT  = 2'b00,
      FETCH = 2'b01,
      EXEC  = 2'b10,
      BAD   = 2'b11
   } state_t;

   state_t     state;
   logic [7:0] pcReg;
   logic [7:0] irReg;
   logic       stepPrev;

   // stepPrev resets high so a step already asserted at release is not an edge.
   always_ff @(posedge clk or negedge resetBar) begin
      if (!resetBar) begin
         state      <= HALT;
         pcReg      <= 8'h00;
         irReg      <= 8'h00;
         instrCount <= 16'h0000;
         stepPrev   <= 1'b1;
      end else begin
         stepPrev <= step;
         case (state)
            HALT: begin
               if (run || (step && !stepPrev))
                  state <= FETCH;
            end
            FETCH: begin
               irReg <= bus.dataBus;
               pcReg <= pcReg + 8'd1;
               state <= EXEC;
            end
            EXEC: begin
               if (bus.doJump)
                  pcReg <= bus.dataBus;
               else if (bus.immediate)
                  pcReg <= pcReg + 8'd1;
               instrCount <= instrCount + 16'd1;
               state      <= run ? FETCH : HALT;
            end
            default: state <= HALT;
         endcase
      end
   end

   assign phase       = state;
   assign fetchStrobe = (state == FETCH);
   assign execValid   = (state == EXEC);
   assign halted      = (state == HALT);
   assign bus.pc      = pcReg;
   assign bus.ir      = irReg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit: reset, free-run, jump/immediate,
// pc wrap, run drop, single-step and asynchronous reset behaviour.
module tb_fetch_unit;
   logic        clk;
   logic        resetBar;
   logic        run;
   logic        step;
   logic [1:0]  phase;
   logic        fetchStrobe;
   logic        execValid;
   logic        halted;
   logic [15:0] instrCount;
   int          testsRun;
   int          testsFailed;
   int          fetchSeen;
   int          execSeen;

   fetch_unit_if busIf ();

   fetch_unit dut (
      .clk         (clk),
      .resetBar    (resetBar),
      .run         (run),
      .step        (step),
      .bus         (busIf.master),
      .phase       (phase),
      .fetchStrobe (fetchStrobe),
      .execValid   (execValid),
      .halted      (halted),
      .instrCount  (instrCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic setBus(input logic [7:0] d, input logic j, input logic im);
      busIf.dataBus   = d;
      busIf.doJump    = j;
      busIf.immediate = im;
   endtask

   initial begin
      testsRun = 0; testsFailed = 0;
      resetBar = 1'b0; run = 1'b0; step = 1'b0;
      setBus(8'h00, 1'b0, 1'b0);
      #12;
      @(negedge clk);
      chk("rst_phase", {14'd0, phase}, 16'h0000);
      chk("rst_halted", {15'd0, halted}, 16'h0001);
      chk("rst_pc", {8'd0, busIf.pc}, 16'h0000);
      chk("rst_ir", {8'd0, busIf.ir}, 16'h0000);
      chk("rst_cnt", instrCount, 16'h0000);

      // free run: first fetch from address 0
      resetBar = 1'b1; run = 1'b1; setBus(8'h12, 1'b0, 1'b0);
      tick();
      chk("fr_phase_fetch", {14'd0, phase}, 16'h0001);
      chk("fr_strobe", {15'd0, fetchStrobe}, 16'h0001);
      chk("fr_pc_fetch", {8'd0, busIf.pc}, 16'h0000);
      tick();
      chk("fr_phase_exec", {14'd0, phase}, 16'h0002);
      chk("fr_execValid", {15'd0, execValid}, 16'h0001);
      chk("fr_ir", {8'd0, busIf.ir}, 16'h0012);
      chk("fr_pc_exec", {8'd0, busIf.pc}, 16'h0001);
      setBus(8'h34, 1'b0, 1'b0);
      tick();
      chk("fr_cnt", instrCount, 16'h0001);
      chk("fr_pc_hold", {8'd0, busIf.pc}, 16'h0001);
      chk("fr_ir_hold", {8'd0, busIf.ir}, 16'h0012);

      // jump beats immediate
      setBus(8'h77, 1'b0, 1'b0);
      tick();
      chk("jmp_pc_exec", {8'd0, busIf.pc}, 16'h0002);
      setBus(8'hA5, 1'b1, 1'b1);
      tick();
      chk("jmp_pc", {8'd0, busIf.pc}, 16'h00A5);
      chk("jmp_phase", {14'd0, phase}, 16'h0001);
      chk("jmp_cnt", instrCount, 16'h0002);

      // immediate consumes operand byte
      setBus(8'h10, 1'b0, 1'b0);
      tick();
      chk("imm_ir", {8'd0, busIf.ir}, 16'h0010);
      setBus(8'h10, 1'b0, 1'b1);
      tick();
      chk("imm_pc", {8'd0, busIf.pc}, 16'h00A7);

      // pc wrap: jump to FE, then fetch + immediate
      setBus(8'h20, 1'b0, 1'b0);
      tick();
      setBus(8'hFE, 1'b1, 1'b0);
      tick();
      chk("wrap_setup", {8'd0, busIf.pc}, 16'h00FE);
      setBus(8'h30, 1'b0, 1'b0);
      tick();
      chk("wrap_ff", {8'd0, busIf.pc}, 16'h00FF);
      setBus(8'h30, 1'b0, 1'b1);
      tick();
      chk("wrap_00", {8'd0, busIf.pc}, 16'h0000);
      chk("wrap_cnt", instrCount, 16'h0005);

      // run drops during FETCH: EXEC still completes
      run = 1'b0; setBus(8'h40, 1'b0, 1'b0);
      tick();
      chk("drop_exec", {14'd0, phase}, 16'h0002);
      tick();
      chk("drop_halted", {15'd0, halted}, 16'h0001);
      chk("drop_cnt", instrCount, 16'h0006);
      setBus(8'h99, 1'b1, 1'b1);
      tick(); tick(); tick();
      chk("halt_pc", {8'd0, busIf.pc}, 16'h0001);
      chk("halt_ir", {8'd0, busIf.ir}, 16'h0040);
      chk("halt_cnt", instrCount, 16'h0006);
      chk("halt_phase", {14'd0, phase}, 16'h0000);

      // single step held high for 10 clocks
      setBus(8'h50, 1'b0, 1'b0);
      step = 1'b1;
      fetchSeen = 0; execSeen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (fetchStrobe) fetchSeen++;
         if (execValid) execSeen++;
      end
      step = 1'b0;
      chk("step_fetches", fetchSeen[15:0], 16'h0001);
      chk("step_execs", execSeen[15:0], 16'h0001);
      chk("step_cnt", instrCount, 16'h0007);
      chk("step_ir", {8'd0, busIf.ir}, 16'h0050);
      chk("step_halted", {15'd0, halted}, 16'h0001);

      // step high across reset release must not fire
      resetBar = 1'b0; step = 1'b1;
      @(negedge clk);
      resetBar = 1'b1;
      tick(); tick(); tick();
      chk("rststep_halted", {15'd0, halted}, 16'h0001);
      chk("rststep_cnt", instrCount, 16'h0000);

      // async reset mid-EXEC at count 5
      step = 1'b0; run = 1'b1; setBus(8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) tick();
      chk("mid_phase", {14'd0, phase}, 16'h0002);
      chk("mid_cnt", instrCount, 16'h0005);
      chk("mid_pc", {8'd0, busIf.pc}, 16'h0006);
      resetBar = 1'b0;
      #1;
      chk("ar_phase", {14'd0, phase}, 16'h0000);
      chk("ar_cnt", instrCount, 16'h0000);
      chk("ar_pc", {8'd0, busIf.pc}, 16'h0000);
      chk("ar_ir", {8'd0, busIf.ir}, 16'h0000);
      chk("ar_halted", {15'd0, halted}, 16'h0001);
      @(negedge clk);
      resetBar = 1'b1;
      tick();
      chk("post_fetch", {14'd0, phase}, 16'h0001);
      chk("post_pc", {8'd0, busIf.pc}, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
